// File: rtl/oric_tap_loader.sv
// Oric TAP loader.
// Captures a TAP image arriving on the MiST data_io link, buffers each byte in a
// small FIFO and writes it into SDRAM port2 with a toggle request/ack handshake.
// The image lands above the 64K Oric RAM window. The block reports the image
// length, a ready flag once every byte is committed, and a sticky overflow flag.
module oric_tap_loader #(
  parameter int unsigned       ADDR_W    = 22,
  parameter logic [ADDR_W-1:0] TAP_BASE  = 22'h010000,
  parameter logic [ADDR_W-1:0] MAX_LEN   = 22'h3F0000,
  parameter logic [7:0]        TAP_INDEX = 8'd1,
  parameter int unsigned       FIFO_AW   = 3
) (
  input  logic              clk,
  input  logic              init_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              port2_req,
  input  logic              port2_ack,
  output logic [ADDR_W-2:0] port2_a,
  output logic [1:0]        port2_ds,
  output logic              port2_we,
  output logic [15:0]       port2_d,
  output logic [ADDR_W-1:0] tap_size,
  output logic              tap_ready,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned       DEPTH = 2 ** FIFO_AW;
  localparam int unsigned       ENT_W = ADDR_W + 8;
  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]  ONE_C = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0]  FULL_C = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // FIFO storage and pointers
  logic [ENT_W-1:0]   fifo_mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;

  // Handshake FSM and port2 output registers
  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic [ADDR_W-2:0]  a_q, a_d;
  logic [1:0]         ds_q, ds_d;
  logic               we_q, we_d;
  logic [15:0]        d_q, d_d;

  // Download tracking and status registers
  logic               dl_q;
  logic               active_q, active_d;
  logic [ADDR_W-1:0]  size_q, size_d;
  logic               ready_q, ready_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;

  // Datapath helpers
  logic               start_s, accept_en_s, in_range_s;
  logic               fifo_empty_s, fifo_full_s;
  logic               push_s, pop_s, drop_s;
  logic [ADDR_W-1:0]  push_addr_s, addr_p1_s, head_addr_s;
  logic [7:0]         head_data_s;

  // Accept/drop decisions; a pop in the same cycle frees a slot in a full FIFO
  always_comb begin
    start_s      = ioctl_download & ~dl_q & (ioctl_index == TAP_INDEX);
    accept_en_s  = active_q & ioctl_download;
    in_range_s   = (ioctl_addr < MAX_LEN);
    fifo_empty_s = (count_q == '0);
    fifo_full_s  = (count_q == FULL_C);
    pop_s        = (state_q == ST_IDLE) & ~fifo_empty_s;
    push_s       = ioctl_wr & accept_en_s & in_range_s & (~fifo_full_s | pop_s);
    drop_s       = ioctl_wr & accept_en_s & ~push_s;
    push_addr_s  = TAP_BASE + ioctl_addr;
    addr_p1_s    = ioctl_addr + ONE_A;
    head_addr_s  = fifo_mem_q[rd_ptr_q][ENT_W-1:8];
    head_data_s  = fifo_mem_q[rd_ptr_q][7:0];
  end

  // FIFO occupancy: simultaneous push and pop leaves the count unchanged
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  // FIFO entry storage (data only, needs no reset)
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= {push_addr_s, ioctl_dout};
    end
  end

  // FIFO pointers and count
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      count_q <= count_d;
    end
  end

  // Handshake FSM: issue one byte per toggle, then wait for the ack to match
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    a_d     = a_q;
    ds_d    = ds_q;
    we_d    = we_q;
    d_d     = d_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          a_d     = head_addr_s[ADDR_W-1:1];
          ds_d    = head_addr_s[0] ? 2'b10 : 2'b01;
          d_d     = {head_data_s, head_data_s};
          req_d   = ~req_q;
          we_d    = 1'b1;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (port2_ack == req_q) begin
          we_d    = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        we_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and port2 output registers
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      a_q     <= '0;
      ds_q    <= 2'b00;
      we_q    <= 1'b0;
      d_q     <= 16'h0000;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      a_q     <= a_d;
      ds_q    <= ds_d;
      we_q    <= we_d;
      d_q     <= d_d;
    end
  end

  // Download session status: start clears it, drain completion raises ready
  always_comb begin
    active_d = active_q;
    size_d   = size_q;
    ready_d  = ready_q;
    ovf_d    = ovf_q;
    if (start_s) begin
      active_d = 1'b1;
      size_d   = '0;
      ready_d  = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      if (push_s && (addr_p1_s > size_q)) begin
        size_d = addr_p1_s;
      end else begin
        size_d = size_q;
      end
      if (drop_s) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
      if (active_q && !ioctl_download && fifo_empty_s && (state_q == ST_IDLE)) begin
        active_d = 1'b0;
        ready_d  = 1'b1;
      end else begin
        active_d = active_q;
        ready_d  = ready_q;
      end
    end
    busy_d = active_d | (count_d != '0) | (state_d != ST_IDLE);
  end

  // Status registers and download edge tracker
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      dl_q     <= 1'b0;
      active_q <= 1'b0;
      size_q   <= '0;
      ready_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      dl_q     <= ioctl_download;
      active_q <= active_d;
      size_q   <= size_d;
      ready_q  <= ready_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
    end
  end

  assign port2_req = req_q;
  assign port2_a   = a_q;
  assign port2_ds  = ds_q;
  assign port2_we  = we_q;
  assign port2_d   = d_q;
  assign tap_size  = size_q;
  assign tap_ready = ready_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_oric_tap_loader.sv
// Directed bench for oric_tap_loader with a toggle-ack SDRAM port2 responder.
module tb_oric_tap_loader;

  logic        clk = 1'b0;
  logic        init_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [21:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        port2_req;
  logic        port2_ack = 1'b0;
  logic [20:0] port2_a;
  logic [1:0]  port2_ds;
  logic        port2_we;
  logic [15:0] port2_d;
  logic [21:0] tap_size;
  logic        tap_ready;
  logic        overflow;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  // responder state
  int          ack_delay = 4;
  int          ack_cnt   = 0;
  logic        req_seen  = 1'b0;
  int          we_bad    = 0;
  logic [20:0] log_a[$];
  logic [1:0]  log_ds[$];
  logic [15:0] log_d[$];

  oric_tap_loader dut (
    .clk(clk), .init_n(init_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
    .port2_ds(port2_ds), .port2_we(port2_we), .port2_d(port2_d),
    .tap_size(tap_size), .tap_ready(tap_ready), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // SDRAM port2 model: log each new request, ack it after ack_delay cycles
  always @(negedge clk) begin
    if (!init_n) begin
      req_seen  = 1'b0;
      ack_cnt   = 0;
      port2_ack = 1'b0;
    end else begin
      if (port2_req != req_seen) begin
        req_seen = port2_req;
        log_a.push_back(port2_a);
        log_ds.push_back(port2_ds);
        log_d.push_back(port2_d);
        if (port2_we !== 1'b1) we_bad++;
      end
      if (port2_req != port2_ack) begin
        ack_cnt++;
        if (ack_cnt >= ack_delay) begin
          port2_ack = port2_req;
          ack_cnt   = 0;
        end
      end
    end
  end

  task automatic clear_log();
    log_a.delete();
    log_ds.delete();
    log_d.delete();
    we_bad = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(negedge clk);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    @(negedge clk);
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr_byte(input logic [21:0] addr, input logic [7:0] data);
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    @(negedge clk);
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_ready(input string nm);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (tap_ready) break;
    end
    checks++;
    if (tap_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_timeout got=%b want=1", nm, tap_ready);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({port2_req, port2_we, port2_ds} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=0000", {port2_req, port2_we, port2_ds});
    end
    checks++;
    if ({port2_a, port2_d} !== 37'd0) begin
      failures++;
      $display("FAIL reset_data got=%h want=0", {port2_a, port2_d});
    end
    checks++;
    if ({tap_size, tap_ready, overflow, busy} !== 25'd0) begin
      failures++;
      $display("FAIL reset_status got=%h want=0", {tap_size, tap_ready, overflow, busy});
    end
  endtask

  task automatic test_other_index();
    clear_log();
    start_dl(8'd0);
    wr_byte(22'd0, 8'h11);
    wr_byte(22'd1, 8'h22);
    end_dl();
    cycles(10);
    checks++;
    if (log_d.size() != 0) begin
      failures++;
      $display("FAIL idx0_no_req got=%0d want=0", log_d.size());
    end
    checks++;
    if ({tap_size, tap_ready, overflow, busy} !== 25'd0) begin
      failures++;
      $display("FAIL idx0_status got=%h want=0", {tap_size, tap_ready, overflow, busy});
    end
  endtask

  task automatic test_basic();
    logic [20:0] ea [3] = '{21'h008000, 21'h008000, 21'h008001};
    logic [1:0]  eds[3] = '{2'b01, 2'b10, 2'b01};
    logic [15:0] ed [3] = '{16'hAAAA, 16'hBBBB, 16'hCCCC};
    ack_delay = 4;
    clear_log();
    start_dl(8'd1);
    wr_byte(22'd0, 8'hAA);
    wr_byte(22'd1, 8'hBB);
    wr_byte(22'd2, 8'hCC);
    end_dl();
    wait_ready("basic");
    checks++;
    if (log_d.size() != 3) begin
      failures++;
      $display("FAIL basic_count got=%0d want=3", log_d.size());
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= log_d.size() || {log_a[i], log_ds[i], log_d[i]} !== {ea[i], eds[i], ed[i]}) begin
        failures++;
        $display("FAIL basic_entry%0d got=%h/%b/%h want=%h/%b/%h", i,
                 (i < log_a.size()) ? log_a[i] : 21'h0, (i < log_ds.size()) ? log_ds[i] : 2'b0,
                 (i < log_d.size()) ? log_d[i] : 16'h0, ea[i], eds[i], ed[i]);
      end
    end
    checks++;
    if ({tap_size, overflow, busy, port2_we, we_bad != 0} !== {22'd3, 4'b0000}) begin
      failures++;
      $display("FAIL basic_status size=%h ovf=%b busy=%b we=%b we_bad=%0d want 3/0/0/0/0",
               tap_size, overflow, busy, port2_we, we_bad);
    end
  endtask

  task automatic test_burst();
    ack_delay = 20;
    clear_log();
    start_dl(8'd1);
    for (int i = 0; i < 12; i++) wr_byte(22'(i), 8'(8'h10 + i));
    end_dl();
    wait_ready("burst");
    checks++;
    if (log_d.size() != 9) begin
      failures++;
      $display("FAIL burst_count got=%0d want=9", log_d.size());
    end
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (i >= log_d.size() || log_d[i] !== {8'(8'h10 + i), 8'(8'h10 + i)} ||
          log_a[i] !== 21'(21'h008000 + i / 2)) begin
        failures++;
        $display("FAIL burst_entry%0d got=%h/%h want=%h/%h", i,
                 (i < log_a.size()) ? log_a[i] : 21'h0, (i < log_d.size()) ? log_d[i] : 16'h0,
                 21'(21'h008000 + i / 2), {8'(8'h10 + i), 8'(8'h10 + i)});
      end
    end
    checks++;
    if ({overflow, tap_size} !== {1'b1, 22'd9}) begin
      failures++;
      $display("FAIL burst_status ovf=%b size=%h want 1/9", overflow, tap_size);
    end
  endtask

  task automatic test_max_len();
    ack_delay = 2;
    clear_log();
    start_dl(8'd1);
    wr_byte(22'h3F0000, 8'h55);
    wr_byte(22'h3EFFFF, 8'h66);
    end_dl();
    wait_ready("maxlen");
    checks++;
    if (log_d.size() != 1) begin
      failures++;
      $display("FAIL maxlen_count got=%0d want=1", log_d.size());
    end
    checks++;
    if (log_d.size() < 1 || {log_a[0], log_ds[0], log_d[0]} !== {21'h1FFFFF, 2'b10, 16'h6666}) begin
      failures++;
      $display("FAIL maxlen_entry got=%h/%b/%h want=1fffff/10/6666",
               (log_a.size() > 0) ? log_a[0] : 21'h0, (log_ds.size() > 0) ? log_ds[0] : 2'b0,
               (log_d.size() > 0) ? log_d[0] : 16'h0);
    end
    checks++;
    if ({overflow, tap_size} !== {1'b1, 22'h3F0000}) begin
      failures++;
      $display("FAIL maxlen_status ovf=%b size=%h want 1/3f0000", overflow, tap_size);
    end
  endtask

  task automatic test_pop_push_full();
    bit seen = 1'b0;
    ack_delay = 20;
    clear_log();
    start_dl(8'd1);
    for (int i = 0; i < 9; i++) wr_byte(22'(i), 8'(8'h30 + i));
    // first posedge at which the ack matches: FSM returns to IDLE there, pops on the next
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (port2_ack == port2_req) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (seen !== 1'b1) begin
      failures++;
      $display("FAIL popfull_ack_timeout got=0 want=1");
    end
    @(negedge clk);
    wr_byte(22'd9, 8'h39);
    end_dl();
    wait_ready("popfull");
    checks++;
    if ({overflow, tap_size} !== {1'b0, 22'd10}) begin
      failures++;
      $display("FAIL popfull_status ovf=%b size=%h want 0/a", overflow, tap_size);
    end
    checks++;
    if (log_d.size() != 10) begin
      failures++;
      $display("FAIL popfull_count got=%0d want=10", log_d.size());
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (i >= log_d.size() || log_d[i] !== {8'(8'h30 + i), 8'(8'h30 + i)}) begin
        failures++;
        $display("FAIL popfull_order%0d got=%h want=%h", i,
                 (i < log_d.size()) ? log_d[i] : 16'h0, {8'(8'h30 + i), 8'(8'h30 + i)});
      end
    end
  endtask

  task automatic test_reset_mid();
    ack_delay = 50;
    clear_log();
    start_dl(8'd1);
    for (int i = 0; i < 5; i++) wr_byte(22'(i), 8'(8'h50 + i));
    cycles(2);
    checks++;
    if ({busy, port2_we} !== 2'b11) begin
      failures++;
      $display("FAIL rstmid_pre busy=%b we=%b want 1/1", busy, port2_we);
    end
    init_n = 1'b0;
    ioctl_download = 1'b0;
    #1;
    checks++;
    if ({port2_req, port2_we, port2_ds, port2_a, port2_d} !== 41'd0) begin
      failures++;
      $display("FAIL rstmid_port got=%h want=0", {port2_req, port2_we, port2_ds, port2_a, port2_d});
    end
    checks++;
    if ({tap_size, tap_ready, overflow, busy} !== 25'd0) begin
      failures++;
      $display("FAIL rstmid_status got=%h want=0", {tap_size, tap_ready, overflow, busy});
    end
    cycles(2);
    init_n = 1'b1;
    cycles(2);
    clear_log();
    ack_delay = 3;
    start_dl(8'd1);
    wr_byte(22'd5, 8'h77);
    end_dl();
    wait_ready("rstmid");
    checks++;
    if (log_d.size() != 1) begin
      failures++;
      $display("FAIL rstmid_count got=%0d want=1", log_d.size());
    end
    checks++;
    if (log_d.size() < 1 || {log_a[0], log_ds[0], log_d[0]} !== {21'h008002, 2'b10, 16'h7777}) begin
      failures++;
      $display("FAIL rstmid_entry got=%h/%b/%h want=8002/10/7777",
               (log_a.size() > 0) ? log_a[0] : 21'h0, (log_ds.size() > 0) ? log_ds[0] : 2'b0,
               (log_d.size() > 0) ? log_d[0] : 16'h0);
    end
    checks++;
    if ({tap_size, overflow} !== {22'd6, 1'b0}) begin
      failures++;
      $display("FAIL rstmid_status size=%h ovf=%b want 6/0", tap_size, overflow);
    end
  endtask

  initial begin
    init_n         = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = 22'd0;
    ioctl_dout     = 8'd0;
    cycles(3);
    test_reset();
    init_n = 1'b1;
    cycles(2);
    test_other_index();
    test_basic();
    test_burst();
    test_max_len();
    test_pop_push_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
